aes_kat_checker: RTL and testbench
==================================

// Module: aes_kat_checker
// PURPOSE
//  Board-level known-answer self-test for the AES-128 encrypt core. Starts on request and steps through NUM_VEC stored
//  (key, plaintext, expected ciphertext) vectors. Each vector goes to the core over a valid/ready handshake; the result
//  is compared per byte and per-byte match is shown on LEDs. Pass/fail, first failing index and timeout are latched.
//  Sits between the top-level board wrapper and AES_top.
// PARAMETERS
//  NUM_VEC    2    number of KAT vectors used (1..8); vectors come from aes_kat_pkg
//  TIMEOUT    64   max cycles from handshake accept to aes_res_valid before a timeout fail (>=2)
//  LED_W      16   LED count; led[i] = byte i of ciphertext matched (LED_W <= 16)
// PORTS
//  clk            in   1    system clock
//  rst_n          in   1    synchronous reset, active-low
//  start          in   1    1-cycle pulse; runs the test; ignored unless IDLE or DONE
//  aes_req_valid  out  1    key/plaintext valid toward core
//  aes_req_ready  in   1    core accepts when valid&ready
//  aes_key        out  128  key of current vector
//  aes_plain      out  128  plaintext of current vector
//  aes_res_valid  in   1    1-cycle pulse, ciphertext valid
//  aes_cipher     in   128  ciphertext from core
//  busy           out  1    run in progress
//  done           out  1    sticky: run finished; cleared by start
//  pass           out  1    sticky: all vectors matched, no timeout; valid when done
//  timeout        out  1    sticky: some vector exceeded TIMEOUT
//  fail_idx       out  3    index of first failing vector; 0 if pass
//  led            out  LED_W  byte-match mask of last compared vector
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, all outputs 0 (aes_key/aes_plain 0). Reset wins over every other input.
//  FSM states: IDLE -> ISSUE -> WAIT -> CHECK -> (ISSUE | DONE); DONE -> ISSUE on start.
//   IDLE/DONE + start: idx=0, done/pass/timeout/fail_idx/led cleared, pass preset 1, go to ISSUE.
//   ISSUE: aes_req_valid=1; key/plain held stable until accepted. On valid&ready -> WAIT and tmo_cnt=0.
//   WAIT: tmo_cnt++ each cycle. Result accepted only in WAIT.
//     - aes_res_valid: capture aes_cipher and go to CHECK.
//     - tmo_cnt==TIMEOUT-1 with no result: timeout=1, pass=0, fail_idx=idx if first fail, go to DONE (run aborts).
//     - aes_res_valid and expiry in the same cycle: the result wins.
//   CHECK: one cycle. led[i] = (cipher byte i == expected byte i), byte 0 = bits[7:0].
//     On mismatch: pass=0; fail_idx=idx if first fail. The run continues.
//     If idx==NUM_VEC-1 go to DONE (done=1); else idx++ and go to ISSUE.
//  aes_res_valid outside WAIT is ignored. A start pulse during a run is ignored.
//  Latency: 1 + handshake wait + core latency + 1 (CHECK) cycles per vector; done is asserted 1 cycle after the last CHECK.
//  busy = state in {ISSUE, WAIT, CHECK}. Outputs are registered, except busy and aes_req_valid, which are decoded from state.
// CONFIGURATION
//  KAT_ERR_INJECT_EN defined:
//   - adds input err_inject (1 bit), sampled at start.
//   - When set, bit 0 of the expected ciphertext of vector 0 is inverted for that run.
//   - Result: pass=0, fail_idx=0, led[0]=0.
//  Not defined: no err_inject port; expected values are used unmodified.
// STRUCTURE
//  aes_kat_pkg:
//   - KAT_MAX=8
//   - state enum kat_state_t {IDLE,ISSUE,WAIT,CHECK,DONE}
//   - constant arrays KAT_KEY/KAT_PLAIN/KAT_CIPHER[KAT_MAX]
//   - vector 0 = FIPS-197 C.1, vector 1 = FIPS-197 B
//  Sub-module aes_kat_rom:
//   - combinational index -> {key, plain, expected}, reading from the package.
//   - Checker FSM, timeout counter and compare logic stay in aes_kat_checker.
// TESTING
//  T1:
//   - stimulus: NUM_VEC=2, ideal core model (ready=1, result 12 cycles after accept), start pulse.
//   - vector 0: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//   - vector 1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, ct 3925841d02dc09fbdc118597196a0b32.
//   - required: done=1, pass=1, timeout=0, led=16'hFFFF.
//  T2: core corrupts byte 3 of vector 1 -> pass=0, fail_idx=1, led=16'hFFF7, done=1.
//  T3: core never asserts aes_res_valid -> timeout=1, pass=0, fail_idx=0, done=1 exactly TIMEOUT cycles after accept.
//  T4: aes_req_ready held low for 5 cycles -> key/plain stable throughout, no early WAIT; run still passes.
//  T5: rst_n low for 1 cycle mid-WAIT -> all outputs 0, IDLE; a later stray aes_res_valid is ignored;
//      a subsequent start passes.
//  T6: KAT_ERR_INJECT_EN defined, err_inject=1 at start -> pass=0, fail_idx=0, led[0]=0.
//      Rerun with err_inject=0 -> pass=1.

Source files
------------

// File: rtl/aes_kat_pkg.sv
// rtl/aes_kat_pkg.sv - AES-128 known-answer vectors and checker state type
package aes_kat_pkg;

  localparam int KAT_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } kat_state_t;

  // Slot 0 is FIPS-197 C.1, slot 1 is FIPS-197 B; the remaining slots repeat them.
  localparam logic [127:0] KAT_KEY [KAT_MAX] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h000102030405060708090a0b0c0d0e0f,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h000102030405060708090a0b0c0d0e0f,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h000102030405060708090a0b0c0d0e0f,
    128'h2b7e151628aed2a6abf7158809cf4f3c
  };

  localparam logic [127:0] KAT_PLAIN [KAT_MAX] = '{
    128'h00112233445566778899aabbccddeeff,
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00112233445566778899aabbccddeeff,
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00112233445566778899aabbccddeeff,
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00112233445566778899aabbccddeeff,
    128'h3243f6a8885a308d313198a2e0370734
  };

  localparam logic [127:0] KAT_CIPHER [KAT_MAX] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h3925841d02dc09fbdc118597196a0b32
  };

endpackage

// File: rtl/aes_kat_checker_rom.sv
// rtl/aes_kat_checker_rom.sv - combinational lookup of one KAT vector by index
module aes_kat_rom
  import aes_kat_pkg::*;
(
  input  logic [2:0]   idx,
  output logic [127:0] key,
  output logic [127:0] plain,
  output logic [127:0] expected
);

  assign key      = KAT_KEY[idx];
  assign plain    = KAT_PLAIN[idx];
  assign expected = KAT_CIPHER[idx];

endmodule

// File: rtl/aes_kat_checker.sv
// rtl/aes_kat_checker.sv - AES-128 known-answer self-test sequencer and comparator
// Optional feature: KAT_ERR_INJECT_EN adds err_inject to corrupt vector 0's expected value.
module aes_kat_checker
  import aes_kat_pkg::*;
#(
  parameter int NUM_VEC = 2,
  parameter int TIMEOUT = 64,
  parameter int LED_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef KAT_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  output logic             aes_req_valid,
  input  logic             aes_req_ready,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_plain,
  input  logic             aes_res_valid,
  input  logic [127:0]     aes_cipher,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [2:0]       fail_idx,
  output logic [LED_W-1:0] led
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

  kat_state_t state, state_nxt;

  logic [2:0]    idx;
  logic [2:0]    load_idx;
  logic [TW-1:0] tmo_cnt;
  logic [127:0]  exp_q;
  logic [127:0]  cipher_q;
  logic [127:0]  rom_key;
  logic [127:0]  rom_plain;
  logic [127:0]  rom_exp;
  logic [15:0]   byte_match;
  logic          tmo_hit;
  logic          last_vec;
  logic          inject;

`ifdef KAT_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  // The ROM is addressed by the vector about to be loaded: 0 at start, idx+1 leaving CHECK.
  assign load_idx = (state == CHECK) ? idx + 3'd1 : 3'd0;

  aes_kat_rom u_rom (
    .idx      (load_idx),
    .key      (rom_key),
    .plain    (rom_plain),
    .expected (rom_exp)
  );

  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_vec = (idx == LAST_IDX);

  always_comb begin
    byte_match = '0;
    for (int i = 0; i < 16; i++) begin
      byte_match[i] = (cipher_q[8*i +: 8] == exp_q[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ISSUE;
      ISSUE:      if (aes_req_ready) state_nxt = WAIT;
      WAIT: begin
        // A result arriving on the expiry cycle still counts.
        if (aes_res_valid)  state_nxt = CHECK;
        else if (tmo_hit)   state_nxt = DONE;
      end
      CHECK:      state_nxt = last_vec ? DONE : ISSUE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign busy          = (state == ISSUE) || (state == WAIT) || (state == CHECK);
  assign aes_req_valid = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      tmo_cnt   <= '0;
      exp_q     <= '0;
      cipher_q  <= '0;
      aes_key   <= '0;
      aes_plain <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      fail_idx  <= '0;
      led       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            done      <= 1'b0;
            pass      <= 1'b1;
            timeout   <= 1'b0;
            fail_idx  <= '0;
            led       <= '0;
            aes_key   <= rom_key;
            aes_plain <= rom_plain;
            exp_q     <= rom_exp ^ {127'd0, inject};
          end
        end
        ISSUE: begin
          if (aes_req_ready) tmo_cnt <= '0;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (aes_res_valid) begin
            cipher_q <= aes_cipher;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            if (pass) fail_idx <= idx;
          end
        end
        CHECK: begin
          led <= byte_match[LED_W-1:0];
          // pass is still set only if no earlier vector failed.
          if (cipher_q != exp_q) begin
            pass <= 1'b0;
            if (pass) fail_idx <= idx;
          end
          if (last_vec) begin
            done <= 1'b1;
          end else begin
            idx       <= idx + 3'd1;
            aes_key   <= rom_key;
            aes_plain <= rom_plain;
            exp_q     <= rom_exp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_kat_checker.sv
// tb/tb_aes_kat_checker.sv - scoreboard bench for aes_kat_checker with a behavioural core model
`timescale 1ns/1ps
module tb_aes_kat_checker;

  localparam int NUM_VEC  = 2;
  localparam int TIMEOUT  = 64;
  localparam int LED_W    = 16;
  localparam int CORE_LAT = 12;

  localparam logic [127:0] REF_KEY [2] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] REF_PT [2] = '{
    128'h00112233445566778899aabbccddeeff, 128'h3243f6a8885a308d313198a2e0370734};
  localparam logic [127:0] REF_CT [2] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h3925841d02dc09fbdc118597196a0b32};

  typedef struct packed {
    logic        s_done;
    logic        s_pass;
    logic        s_tmo;
    logic [2:0]  s_fidx;
    logic [15:0] s_led;
  } st_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             aes_req_valid;
  logic             aes_req_ready = 1'b1;
  logic [127:0]     aes_key;
  logic [127:0]     aes_plain;
  logic             aes_res_valid = 1'b0;
  logic [127:0]     aes_cipher = '0;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [2:0]       fail_idx;
  logic [LED_W-1:0] led;
`ifdef KAT_ERR_INJECT_EN
  logic             err_inject = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int done_cyc = 0;
  int pend = 0;
  int res_count = 0;
  int stall_left = 0;
  bit no_resp = 1'b0;
  bit corrupt_v1 = 1'b0;
  logic [127:0] pend_ct;

  st_t          sb_q[$];
  logic [127:0] exp_key_q[$];
  logic [127:0] exp_pt_q[$];
  logic [127:0] got_key_q[$];
  logic [127:0] got_pt_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_kat_checker #(.NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT), .LED_W(LED_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
`ifdef KAT_ERR_INJECT_EN
    .err_inject    (err_inject),
`endif
    .aes_req_valid (aes_req_valid),
    .aes_req_ready (aes_req_ready),
    .aes_key       (aes_key),
    .aes_plain     (aes_plain),
    .aes_res_valid (aes_res_valid),
    .aes_cipher    (aes_cipher),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .fail_idx      (fail_idx),
    .led           (led)
  );

  function automatic logic [127:0] ref_cipher(input logic [127:0] k);
    for (int i = 0; i < 2; i++) if (k == REF_KEY[i]) return REF_CT[i];
    return '0;
  endfunction

  // Core model: everything changes on the falling edge, so the DUT sees stable inputs.
  always @(negedge clk) begin
    aes_res_valid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        aes_res_valid = 1'b1;
        aes_cipher    = pend_ct;
        res_count     = res_count + 1;
      end
    end
    if (aes_req_valid && stall_left > 0) begin
      aes_req_ready = 1'b0;
      stall_left    = stall_left - 1;
    end else begin
      aes_req_ready = 1'b1;
    end
    if (aes_req_valid && aes_req_ready) begin
      got_key_q.push_back(aes_key);
      got_pt_q.push_back(aes_plain);
      accept_cyc = cyc + 1;
      if (!no_resp) begin
        pend    = CORE_LAT;
        pend_ct = ref_cipher(aes_key);
        if (corrupt_v1 && aes_key == REF_KEY[1]) pend_ct[31:24] = ~pend_ct[31:24];
      end
    end
  end

  function automatic st_t observed();
    return {done, pass, timeout, fail_idx, led};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_run(input st_t e);
    sb_q.push_back(e);
    got_key_q.delete();
    got_pt_q.delete();
    for (int i = 0; i < NUM_VEC; i++) begin
      exp_key_q.push_back(REF_KEY[i]);
      exp_pt_q.push_back(REF_PT[i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (observed() !== st_t'(0)) begin
      n_bad++; $display("FAIL reset_status got=%h want=%h", observed(), st_t'(0));
    end
    n_cmp++;
    if ({busy, aes_req_valid} !== 2'b00) begin
      n_bad++; $display("FAIL reset_busy_valid got=%b want=00", {busy, aes_req_valid});
    end
    n_cmp++;
    if ({aes_key, aes_plain} !== 256'd0) begin
      n_bad++; $display("FAIL reset_key_plain got=%h %h want=0", aes_key, aes_plain);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_start busy got=%b want=0", busy);
    end
  endtask

  task automatic test_pass(input string tag);
    st_t e;
    bit ok;
    push_run('{1'b1, 1'b1, 1'b0, 3'd0, 16'hFFFF});
    pulse_start();
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_done_wait got=no_done want=done", tag); end
    e = sb_q.pop_front();
    n_cmp++;
    if (observed() !== e) begin
      n_bad++; $display("FAIL %s_status got=%h want=%h", tag, observed(), e);
    end
    while (exp_key_q.size() > 0) begin
      logic [127:0] wk, wp, gk, gp;
      wk = exp_key_q.pop_front();
      wp = exp_pt_q.pop_front();
      gk = (got_key_q.size() > 0) ? got_key_q.pop_front() : 'x;
      gp = (got_pt_q.size() > 0) ? got_pt_q.pop_front() : 'x;
      n_cmp++;
      if ({gk, gp} !== {wk, wp}) begin
        n_bad++; $display("FAIL %s_req got=%h/%h want=%h/%h", tag, gk, gp, wk, wp);
      end
    end
  endtask

  task automatic test_corrupt();
    st_t e;
    bit ok;
    corrupt_v1 = 1'b1;
    push_run('{1'b1, 1'b0, 1'b0, 3'd1, 16'hFFF7});
    pulse_start();
    wait_done(ok);
    corrupt_v1 = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (observed() !== e || !ok) begin
      n_bad++; $display("FAIL corrupt_status got=%h want=%h", observed(), e);
    end
    exp_key_q.delete(); exp_pt_q.delete();
  endtask

  task automatic test_timeout();
    st_t e;
    bit ok;
    no_resp = 1'b1;
    push_run('{1'b1, 1'b0, 1'b1, 3'd0, 16'h0000});
    pulse_start();
    wait_done(ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (observed() !== e || !ok) begin
      n_bad++; $display("FAIL timeout_status got=%h want=%h", observed(), e);
    end
    n_cmp++;
    if (done_cyc - accept_cyc != TIMEOUT) begin
      n_bad++; $display("FAIL timeout_latency got=%0d want=%0d", done_cyc - accept_cyc, TIMEOUT);
    end
    no_resp = 1'b0;
    exp_key_q.delete(); exp_pt_q.delete();
  endtask

  task automatic test_stall();
    stall_left = 5;
    got_key_q.delete();
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if ({aes_req_valid, aes_key, aes_plain} !== {1'b1, REF_KEY[0], REF_PT[0]}) begin
        n_bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h want=1/%h/%h", k,
                          aes_req_valid, aes_key, aes_plain, REF_KEY[0], REF_PT[0]);
      end
      @(negedge clk);
    end
    begin
      st_t e;
      bit ok;
      wait_done(ok);
      e = '{1'b1, 1'b1, 1'b0, 3'd0, 16'hFFFF};
      n_cmp++;
      if (observed() !== e || !ok) begin
        n_bad++; $display("FAIL stall_status got=%h want=%h", observed(), e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int guard;
    got_key_q.delete();
    pulse_start();
    guard = 0;
    while (got_key_q.size() == 0 && guard < 50) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({observed(), busy, aes_req_valid, aes_key, aes_plain} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs got=%h/%b/%b/%h want=0", observed(), busy,
                        aes_req_valid, aes_key);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({busy, done, led} !== '0) begin
      n_bad++; $display("FAIL stray_result got=%b/%b/%h want=0/0/0", busy, done, led);
    end
    test_pass("after_reset");
  endtask

`ifdef KAT_ERR_INJECT_EN
  task automatic test_err_inject();
    st_t e;
    bit ok;
    int guard;
    int base;
    err_inject = 1'b1;
    base = res_count;
    push_run('{1'b1, 1'b0, 1'b0, 3'd0, 16'hFFFF});
    pulse_start();
    err_inject = 1'b0;
    guard = 0;
    while (res_count == base && guard < 100) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (led[0] !== 1'b0) begin
      n_bad++; $display("FAIL inject_led0 got=%b want=0", led[0]);
    end
    wait_done(ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (observed() !== e || !ok) begin
      n_bad++; $display("FAIL inject_status got=%h want=%h", observed(), e);
    end
    exp_key_q.delete(); exp_pt_q.delete();
    test_pass("inject_off");
  endtask
`endif

  initial begin
    test_reset();
    test_pass("basic");
    test_corrupt();
    test_timeout();
    test_stall();
    test_reset_mid_wait();
`ifdef KAT_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
